// File: rtl/decode_pkg.sv
// Shared opcode, ALU-operation and immediate-format definitions for the RV32I decode stage.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // 17 distinct operations, so the code needs 5 bits.
  localparam int unsigned ALU_CODE_W = 5;
  typedef logic [ALU_CODE_W-1:0] alu_code_t;

  localparam alu_code_t ALU_ADD    = 5'd0;
  localparam alu_code_t ALU_SUB    = 5'd1;
  localparam alu_code_t ALU_SLL    = 5'd2;
  localparam alu_code_t ALU_SLT    = 5'd3;
  localparam alu_code_t ALU_SLTU   = 5'd4;
  localparam alu_code_t ALU_XOR    = 5'd5;
  localparam alu_code_t ALU_SRL    = 5'd6;
  localparam alu_code_t ALU_SRA    = 5'd7;
  localparam alu_code_t ALU_OR     = 5'd8;
  localparam alu_code_t ALU_AND    = 5'd9;
  localparam alu_code_t ALU_PASS_B = 5'd10;
  localparam alu_code_t ALU_BEQ    = 5'd11;
  localparam alu_code_t ALU_BNE    = 5'd12;
  localparam alu_code_t ALU_BLT    = 5'd13;
  localparam alu_code_t ALU_BGE    = 5'd14;
  localparam alu_code_t ALU_BLTU   = 5'd15;
  localparam alu_code_t ALU_BGEU   = 5'd16;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  // alt selects SUB (funct3=000) or SRA/SRAI (funct3=101); callers gate it per opcode.
  function automatic alu_code_t arith_op(input logic [2:0] funct3, input logic alt);
    alu_code_t op;
    case (funct3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator: selects the I/S/B/U/J layout and sign-extends to XLEN.
module imm_gen
  import decode_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [31:7]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] raw;

  always_comb begin
    raw = '0;
    case (fmt)
      FMT_I:   raw = {{20{instr[31]}}, instr[31:20]};
      FMT_S:   raw = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B:   raw = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   raw = {instr[31:12], 12'b0};
      FMT_J:   raw = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: raw = '0;
    endcase
    imm = XLEN'($signed(raw));
  end

endmodule

// File: rtl/decode_stage.sv
// Registered RV32I decode stage: control decode, valid/ready output register, flush and
// load-use bubble insertion.
module decode_stage
  import decode_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ALU_OP_W  = 5,
  parameter bit          HAZARD_EN = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instr,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [4:0]          read_reg1,
  output logic [4:0]          read_reg2,
  output logic [4:0]          write_reg,
  output logic                is_write,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                alusrc,
  output logic                pcsrc,
  output logic                regwritesrc,
  output logic                is_access_memory,
  output logic                is_write_memory,
  output logic [XLEN-1:0]     imm,
  output logic                illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [4:0] rd;
  logic [4:0] rs1;
  logic [4:0] rs2;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  logic            use_rs1;
  logic            use_rs2;
  logic            use_rd;
  logic            d_write;
  logic            d_alusrc;
  logic            d_pcsrc;
  logic            d_rws;
  logic            d_mem;
  logic            d_memw;
  logic            d_illegal;
  alu_code_t       d_alu;
  imm_fmt_e        d_fmt;
  logic [XLEN-1:0] d_imm;

  always_comb begin
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    use_rd    = 1'b0;
    d_write   = 1'b0;
    d_alusrc  = 1'b0;
    d_pcsrc   = 1'b0;
    d_rws     = 1'b0;
    d_mem     = 1'b0;
    d_memw    = 1'b0;
    d_illegal = 1'b0;
    d_alu     = ALU_ADD;
    d_fmt     = FMT_R;
    case (opcode)
      OPC_LUI, OPC_AUIPC: begin
        d_fmt    = FMT_U;
        use_rd   = 1'b1;
        d_write  = 1'b1;
        d_alusrc = 1'b1;
        d_rws    = 1'b1;
        d_alu    = (opcode == OPC_LUI) ? ALU_PASS_B : ALU_ADD;
      end
      OPC_JAL: begin
        d_fmt   = FMT_J;
        use_rd  = 1'b1;
        d_write = 1'b1;
        d_pcsrc = 1'b1;
        d_rws   = 1'b1;
      end
      OPC_JALR: begin
        d_fmt     = FMT_I;
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        d_write   = 1'b1;
        d_pcsrc   = 1'b1;
        d_rws     = 1'b1;
        d_illegal = (funct3 != 3'b000);
      end
      OPC_BRANCH: begin
        d_fmt   = FMT_B;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        d_pcsrc = 1'b1;
        case (funct3)
          3'b000:  d_alu = ALU_BEQ;
          3'b001:  d_alu = ALU_BNE;
          3'b100:  d_alu = ALU_BLT;
          3'b101:  d_alu = ALU_BGE;
          3'b110:  d_alu = ALU_BLTU;
          3'b111:  d_alu = ALU_BGEU;
          default: d_illegal = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        d_fmt     = FMT_I;
        use_rd    = 1'b1;
        use_rs1   = 1'b1;
        d_write   = 1'b1;
        d_alusrc  = 1'b1;
        d_mem     = 1'b1;
        d_illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        d_fmt     = FMT_S;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
        d_alusrc  = 1'b1;
        d_mem     = 1'b1;
        d_memw    = 1'b1;
        d_illegal = (funct3 > 3'b010);
      end
      OPC_OPIMM: begin
        d_fmt    = FMT_I;
        use_rd   = 1'b1;
        use_rs1  = 1'b1;
        d_write  = 1'b1;
        d_alusrc = 1'b1;
        d_rws    = 1'b1;
        d_alu    = arith_op(funct3, (funct3 == 3'b101) && in_instr[30]);
      end
      OPC_OP: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        d_write = 1'b1;
        d_rws   = 1'b1;
        d_alu   = arith_op(funct3, in_instr[30]);
      end
      default: d_illegal = 1'b1;
    endcase
    if (!use_rd || rd == '0) d_write = 1'b0;
    if (d_illegal) begin
      d_write = 1'b0;
      d_pcsrc = 1'b0;
      d_mem   = 1'b0;
      d_memw  = 1'b0;
    end
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (d_fmt),
    .imm   (d_imm)
  );

  // A legal load in the output register is the only producer that can stall a consumer.
  logic hazard;
  logic out_is_load;

  assign out_is_load = is_access_memory && !is_write_memory;

  always_comb begin
    hazard = HAZARD_EN && in_valid && out_valid && out_is_load && (write_reg != '0) &&
             ((use_rs1 && rs1 == write_reg) || (use_rs2 && rs2 == write_reg));
  end

  logic advance;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid        <= 1'b0;
      out_pc           <= '0;
      read_reg1        <= '0;
      read_reg2        <= '0;
      write_reg        <= '0;
      is_write         <= 1'b0;
      alu_op           <= '0;
      alusrc           <= 1'b0;
      pcsrc            <= 1'b0;
      regwritesrc      <= 1'b0;
      is_access_memory <= 1'b0;
      is_write_memory  <= 1'b0;
      imm              <= '0;
      illegal          <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid        <= in_valid && !hazard;
      out_pc           <= in_pc;
      read_reg1        <= use_rs1 ? rs1 : 5'd0;
      read_reg2        <= use_rs2 ? rs2 : 5'd0;
      write_reg        <= use_rd ? rd : 5'd0;
      is_write         <= d_write;
      alu_op           <= ALU_OP_W'(d_alu);
      alusrc           <= d_alusrc;
      pcsrc            <= d_pcsrc;
      regwritesrc      <= d_rws;
      is_access_memory <= d_mem;
      is_write_memory  <= d_memw;
      imm              <= d_imm;
      illegal          <= d_illegal;
    end
  end

endmodule
